// File: rtl/uart_periph_hub_if.sv
// CPU-side bus of the UART/LED peripheral hub: RX byte stream, error flags and LED register.
interface uart_periph_hub_if #(
  parameter int DATA_BITS = 8,
  parameter int LED_WIDTH = 8
);
  logic                 int0;
  logic [DATA_BITS-1:0] uart_read_byte;
  logic                 cpu_end_read;
  logic                 uart_overrun;
  logic                 overrun_clr;
  logic                 frame_err;
  logic                 leds_write;
  logic [LED_WIDTH-1:0] leds_write_byte;
  logic [LED_WIDTH-1:0] leds;

  modport slave (
    output int0, uart_read_byte, uart_overrun, frame_err, leds,
    input  cpu_end_read, overrun_clr, leds_write, leds_write_byte
  );

  modport master (
    input  int0, uart_read_byte, uart_overrun, frame_err, leds,
    output cpu_end_read, overrun_clr, leds_write, leds_write_byte
  );
endinterface

// File: rtl/uart_periph_hub.sv
// Peripheral hub: oversampled 8N1-style UART receiver, show-ahead RX FIFO with
// level interrupt and overrun/framing flags, plus a registered LED port.
module uart_periph_hub #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int LED_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_in,
  uart_periph_hub_if.slave bus
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                 rx_meta, rxs;
  state_t               state, state_n;
  logic [CW-1:0]        cyc, cyc_n;
  logic [BW-1:0]        bitc, bitc_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 push, ferr_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      count;
  logic                 full, empty, do_push, do_pop, ovr_set;
  logic                 overrun_q, frame_err_q;
  logic [LED_WIDTH-1:0] leds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
      cyc     <= '0;
      bitc    <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= uart_in;
      rxs     <= rx_meta;
      state   <= state_n;
      cyc     <= cyc_n;
      bitc    <= bitc_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    cyc_n   = cyc + CW'(1);
    bitc_n  = bitc;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cyc_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cyc == HALF_LAST) begin
          cyc_n   = '0;
          bitc_n  = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cyc == BIT_LAST) begin
          cyc_n         = '0;
          shreg_n[bitc] = rxs;
          if (bitc == LAST_BIT) state_n = STOP;
          else                  bitc_n  = bitc + BW'(1);
        end
      end
      STOP: begin
        if (cyc == BIT_LAST) begin
          cyc_n   = '0;
          state_n = IDLE;
          push    = rxs;
          ferr_n  = !rxs;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = bus.cpu_end_read && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign ovr_set = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      leds_q      <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CNTW'(1);
      else if (do_pop && !do_push) count <= count - CNTW'(1);
      if (ovr_set)              overrun_q <= 1'b1;
      else if (bus.overrun_clr) overrun_q <= 1'b0;
      frame_err_q <= ferr_n;
      if (bus.leds_write) leds_q <= bus.leds_write_byte;
    end
  end

  assign bus.int0           = !empty;
  assign bus.uart_read_byte = empty ? '0 : mem[rd_ptr];
  assign bus.uart_overrun   = overrun_q;
  assign bus.frame_err      = frame_err_q;
  assign bus.leds           = leds_q;
endmodule
